// File: rtl/am_lock_rx.sv
// am_lock_rx: alignment-marker lock FSM for a 66-bit block receiver (4 lanes).
// Define AM_LOCK_RX_ASSERT_EN to compile in simulation-only consistency assertions.
module am_lock_rx #(
    parameter int BLOCK_W = 66,
    parameter int LANE_N  = 4,
    parameter int GAP_N   = 16383
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               valid_i,
    input  logic               signal_v_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               lock_v_o,
    output logic               lite_am_v_o,
    output logic               lite_lock_v_o,
    output logic [LANE_N-1:0]  lane_o
);
    localparam int CNT_W = $clog2(GAP_N + 1);
    localparam int LW    = (LANE_N > 1) ? $clog2(LANE_N) : 1;

    // {M2,M1,M0} and {M6,M5,M4} per lane, index 0 = lane 0
    localparam logic [3:0][23:0] AM_LO = {24'h3D79A2, 24'h9B65C5, 24'hE6C4F0, 24'h477690};
    localparam logic [3:0][23:0] AM_HI = {24'hC2865D, 24'h649A3A, 24'h193B0F, 24'hB8896F};

    typedef enum logic [2:0] {
        INIT, RESET_CNT, FIND_1ST, COUNT_1, COMP_2ND, COUNT_2, COMP_AM, SLIP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         inv_q, inv_d;
    logic [LW-1:0]      lidx_q, lidx_d;
    logic               lock_q, lock_d;
    logic [LANE_N-1:0]  lane_q, lane_d;
    logic               sticky_q, sticky_d;

    logic [LANE_N-1:0]  match_v;
    logic [LW-1:0]      match_idx;
    logic               any_match, cur_match, cnt_last;
    logic               slip_v;
    logic               unused_dbg;

    for (genvar l = 0; l < LANE_N; l++) begin : g_match
        if (l < 4) begin : g_known
            assign match_v[l] = (block_i[1:0] == 2'b10) &&
                                (block_i[25:2] == AM_LO[l]) &&
                                (block_i[57:34] == AM_HI[l]);
        end else begin : g_none
            assign match_v[l] = 1'b0;
        end
    end

    always_comb begin
        match_idx = '0;
        for (int l = 0; l < LANE_N; l++)
            if (match_v[l]) match_idx = LW'(l);
    end

    assign any_match = |match_v;
    assign cur_match = match_v[lidx_q];
    assign cnt_last  = (cnt_q == CNT_W'(GAP_N - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        lidx_d   = lidx_q;
        lock_d   = lock_q;
        lane_d   = lane_q;
        sticky_d = sticky_q;
        if (!signal_v_i) begin
            state_d  = INIT;
            cnt_d    = '0;
            inv_d    = '0;
            lock_d   = 1'b0;
            lane_d   = '0;
            sticky_d = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    sticky_d = 1'b0;
                    state_d  = RESET_CNT;
                end
                RESET_CNT: begin
                    cnt_d   = '0;
                    inv_d   = '0;
                    state_d = FIND_1ST;
                end
                FIND_1ST: if (valid_i && any_match) begin
                    lidx_d   = match_idx;
                    sticky_d = 1'b0;
                    state_d  = COUNT_1;
                end
                COUNT_1, COUNT_2: if (valid_i) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = (state_q == COUNT_1) ? COMP_2ND : COMP_AM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                COMP_2ND: if (valid_i) begin
                    if (cur_match) begin
                        lock_d  = 1'b1;
                        lane_d  = LANE_N'(1) << lidx_q;
                        state_d = COUNT_2;
                    end else begin
                        sticky_d = 1'b1;
                        state_d  = SLIP;
                    end
                end
                COMP_AM: if (valid_i) begin
                    if (cur_match) begin
                        inv_d   = '0;
                        state_d = COUNT_2;
                    end else if (inv_q == 2'd3) begin
                        sticky_d = 1'b1;
                        state_d  = SLIP;
                    end else begin
                        inv_d   = inv_q + 1'b1;
                        state_d = COUNT_2;
                    end
                end
                SLIP: begin
                    lock_d  = 1'b0;
                    lane_d  = '0;
                    state_d = RESET_CNT;
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            inv_q    <= '0;
            lidx_q   <= '0;
            lock_q   <= 1'b0;
            lane_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inv_q    <= inv_d;
            lidx_q   <= lidx_d;
            lock_q   <= lock_d;
            lane_q   <= lane_d;
            sticky_q <= sticky_d;
        end
    end

    // Sticky term keeps slip visible until the search finds a fresh marker.
    assign slip_v = signal_v_i && (
        (state_q == COMP_2ND && valid_i && !cur_match) ||
        (state_q == COMP_AM && valid_i && !cur_match && inv_q == 2'd3) ||
        (sticky_q && !(state_q == FIND_1ST && valid_i && any_match)));

    assign lock_v_o      = lock_q;
    assign lane_o        = lane_q;
    assign lite_am_v_o   = lock_q && valid_i && (state_q == COMP_AM);
    assign lite_lock_v_o = lock_q && (inv_q == 2'd0);

    // BIP bytes are never compared; slip_v is a debug probe only.
    assign unused_dbg = ^{block_i[33:26], block_i[65:58], slip_v};

`ifdef AM_LOCK_RX_ASSERT_EN
    a_lane_onehot: assert property (@(posedge clk) disable iff (nreset) $onehot0(lane_o));
    a_lock_lane:   assert property (@(posedge clk) disable iff (nreset) lock_v_o |-> (lane_o != '0));
    a_lock_idle:   assert property (@(posedge clk) disable iff (nreset)
                       (state_q == INIT || state_q == FIND_1ST) |-> !lock_v_o);
`else
    // no checkers in this build; datapath identical
`endif
endmodule

// File: tb/tb_am_lock_rx.sv
// Scoreboard bench for am_lock_rx: stimulus queues expectations, a negedge monitor pops them.
// The marker period is shortened through GAP_N so the run stays brief.
module tb_am_lock_rx;
    localparam int G = 63;

    logic        clk = 1'b0;
    logic        nreset;
    logic        valid_i;
    logic        signal_v_i;
    logic [65:0] block_i;
    logic        lock_v_o;
    logic        lite_am_v_o;
    logic        lite_lock_v_o;
    logic [3:0]  lane_o;

    am_lock_rx #(.BLOCK_W(66), .LANE_N(4), .GAP_N(G)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .valid_i      (valid_i),
        .signal_v_i   (signal_v_i),
        .block_i      (block_i),
        .lock_v_o     (lock_v_o),
        .lite_am_v_o  (lite_am_v_o),
        .lite_lock_v_o(lite_lock_v_o),
        .lane_o       (lane_o)
    );

    always #5 clk = ~clk;

    localparam int S_LOCK = 0, S_LANE = 1, S_SLIP = 2, S_LLOCK = 3, S_LAM = 4;

    typedef struct {
        int         cyc;
        string      nm;
        int         sel;
        logic [3:0] v;
    } chk_t;

    chk_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] M0 [4] = '{8'h90, 8'hF0, 8'hC5, 8'hA2};
    logic [7:0] M1 [4] = '{8'h76, 8'hC4, 8'h65, 8'h79};
    logic [7:0] M2 [4] = '{8'h47, 8'hE6, 8'h9B, 8'h3D};
    logic [7:0] M4 [4] = '{8'h6F, 8'h0F, 8'h3A, 8'h5D};
    logic [7:0] M5 [4] = '{8'h89, 8'h3B, 8'h9A, 8'h86};
    logic [7:0] M6 [4] = '{8'hB8, 8'h19, 8'h64, 8'hC2};

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin : mon
        chk_t       c;
        logic [3:0] act;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            c = sbq.pop_front();
            case (c.sel)
                S_LOCK:  act = {3'b000, lock_v_o};
                S_LANE:  act = lane_o;
                S_SLIP:  act = {3'b000, dut.slip_v};
                S_LLOCK: act = {3'b000, lite_lock_v_o};
                default: act = {3'b000, lite_am_v_o};
            endcase
            checks++;
            if (c.cyc != cyc || act !== c.v) begin
                errors++;
                $display("FAIL %s: got %0h want %0h (cycle %0d, queued %0d)", c.nm, act, c.v, cyc, c.cyc);
            end
        end
    end

    function automatic logic [65:0] am_blk(input int l);
        return {8'hA5, M6[l], M5[l], M4[l], 8'h3C, M2[l], M1[l], M0[l], 2'b10};
    endfunction

    function automatic logic [65:0] rnd_blk();
        return {$urandom, $urandom, 2'b01};
    endfunction

    task automatic want(input string nm, input int sel, input logic [3:0] v);
        sbq.push_back('{cyc: cyc, nm: nm, sel: sel, v: v});
    endtask

    task automatic put(input logic v, input logic s, input logic [65:0] b);
        valid_i = v;
        signal_v_i = s;
        block_i = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n valid random blocks, with idle cycles carrying a marker that must be ignored
    task automatic run_rand(input int n, input logic [3:0] lk);
        for (int i = 0; i < n; i++) begin
            if (i % 9 == 4) begin
                put(1'b0, 1'b1, am_blk(2));
                want("gap_slip", S_SLIP, 4'h0);
                want("gap_lock", S_LOCK, lk);
                tick();
            end
            put(1'b1, 1'b1, rnd_blk());
            want("rand_slip", S_SLIP, 4'h0);
            want("rand_lock", S_LOCK, lk);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nreset = 1'b1;
        put(1'b1, 1'b1, am_blk(2));
        tick();
        tick();
        want("rst_lock", S_LOCK, 4'h0);
        want("rst_lane", S_LANE, 4'h0);
        want("rst_slip", S_SLIP, 4'h0);
        want("rst_llock", S_LLOCK, 4'h0);
        want("rst_lam", S_LAM, 4'h0);
        tick();
        nreset = 1'b0;
        put(1'b0, 1'b1, rnd_blk());
        tick();
        tick();

        // first lock on lane 2
        put(1'b1, 1'b1, am_blk(2));
        want("a1_slip", S_SLIP, 4'h0);
        want("a1_lock", S_LOCK, 4'h0);
        tick();
        run_rand(G, 4'h0);
        put(1'b1, 1'b1, am_blk(2));
        want("a2_slip", S_SLIP, 4'h0);
        want("a2_lock_pre", S_LOCK, 4'h0);
        tick();
        want("lock2", S_LOCK, 4'h1);
        want("lane2", S_LANE, 4'b0100);
        want("llock2", S_LLOCK, 4'h1);
        run_rand(G, 4'h1);
        put(1'b1, 1'b1, am_blk(2));
        want("slot_lam", S_LAM, 4'h1);
        want("slot_slip", S_SLIP, 4'h0);
        tick();
        want("slot_llock", S_LLOCK, 4'h1);

        // four consecutive missed slots
        for (int k = 0; k < 4; k++) begin
            run_rand(G, 4'h1);
            put(1'b1, 1'b1, rnd_blk());
            want("miss_lam", S_LAM, 4'h1);
            want("miss_slip", S_SLIP, (k == 3) ? 4'h1 : 4'h0);
            tick();
            if (k < 3) begin
                want("miss_llock", S_LLOCK, 4'h0);
                want("miss_lock", S_LOCK, 4'h1);
            end
        end
        put(1'b1, 1'b1, rnd_blk());
        want("slip_lock_hold", S_LOCK, 4'h1);
        want("slip_sticky", S_SLIP, 4'h1);
        tick();
        put(1'b1, 1'b1, rnd_blk());
        want("unlock", S_LOCK, 4'h0);
        want("unlock_lane", S_LANE, 4'h0);
        want("rcnt_sticky", S_SLIP, 4'h1);
        tick();
        put(1'b1, 1'b1, rnd_blk());
        want("find_sticky", S_SLIP, 4'h1);
        tick();
        put(1'b0, 1'b1, am_blk(1));
        want("find_idle_mk", S_SLIP, 4'h1);
        tick();

        // wrong lane at the second marker
        put(1'b1, 1'b1, am_blk(1));
        want("find_match", S_SLIP, 4'h0);
        tick();
        run_rand(G, 4'h0);
        put(1'b1, 1'b1, am_blk(2));
        want("c2_mismatch", S_SLIP, 4'h1);
        want("c2_lock", S_LOCK, 4'h0);
        tick();
        want("c2_lock_post", S_LOCK, 4'h0);
        put(1'b1, 1'b1, rnd_blk());
        want("slip_state", S_SLIP, 4'h1);
        tick();

        // signal loss overrides sticky slip
        put(1'b1, 1'b0, rnd_blk());
        want("sig_drop_slip", S_SLIP, 4'h0);
        tick();
        want("sig_drop_lock", S_LOCK, 4'h0);
        put(1'b0, 1'b1, rnd_blk());
        want("init_slip", S_SLIP, 4'h0);
        tick();
        put(1'b0, 1'b1, rnd_blk());
        want("rcnt_slip", S_SLIP, 4'h0);
        tick();
        put(1'b1, 1'b1, am_blk(3));
        want("mk3_slip", S_SLIP, 4'h0);
        tick();

        // lock on lane 3, then drop signal
        run_rand(G, 4'h0);
        put(1'b1, 1'b1, am_blk(3));
        want("l3_slip", S_SLIP, 4'h0);
        tick();
        want("lock3", S_LOCK, 4'h1);
        want("lane3", S_LANE, 4'b1000);
        put(1'b1, 1'b0, rnd_blk());
        want("l3_drop_hold", S_LOCK, 4'h1);
        want("l3_drop_slip", S_SLIP, 4'h0);
        tick();
        want("l3_lost", S_LOCK, 4'h0);
        want("l3_lane0", S_LANE, 4'h0);
        want("l3_llock", S_LLOCK, 4'h0);

        put(1'b0, 1'b1, '0);
        tick();
        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
